seven_segment_scan: RTL
=======================

Name: seven_segment_scan

Overview:
- Parametrised, time-multiplexed driver for DIGITS common-anode seven-segment digits on one shared segment bus.
- Successor to the single-digit decoder: adds a load-captured value register, a scan prescaler, digit rotation, anti-ghost blanking, leading-zero suppression and a decimal-point mask.
- Sits between the parking-slot counters (BCD outputs) and the board display pins.

Parameters:
- DIGITS, 4: number of multiplexed digits (1..8).
- SCAN_DIV, 50000: clk cycles per digit slot; minimum 2.
- CNT_W, 16: prescaler width; must satisfy 2**CNT_W >= SCAN_DIV.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- value, input, 4*DIGITS: BCD nibbles; nibble 0 (bits 3:0) is the least significant (rightmost) digit.
- load, input, 1: captures value and dp_in into the holding registers.
- lz_blank, input, 1: enables leading-zero suppression.
- dp_in, input, DIGITS: per-digit decimal point request, 1 = lit.
- out_seg, output, 7: segments {a,b,c,d,e,f,g}, a = bit 6, active-low.
- dp, output, 1: decimal point, active-low.
- an, output, DIGITS: digit enables, active-low; at most one low.

Behaviour:
- Reset (synchronous, active-high): clears hold_val, hold_dp, prescaler and idx to 0. out_seg = 7'b1111111, dp = 1, an = all ones, all on the cycle after the reset edge.
- Load:
  - load = 1 at edge N updates hold_val/hold_dp at N.
  - Change is visible on the pins at edge N+1, when idx selects that digit.
  - Without load, the holding registers are stable; value changes are ignored.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = (count == SCAN_DIV-1).
  - On tick, idx increments and wraps from DIGITS-1 to 0.
- Outputs:
  - All pin outputs are registered.
  - Pins reflect idx and holding registers with 1-cycle latency.
- Anti-ghost: on the first clock after an idx change, an = all ones and out_seg = all ones. The new digit then drives for the remaining SCAN_DIV-1 cycles.
- Decode (active-low): codes 0..9 are standard glyphs.
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - Codes 10..15 display a dash, 1111110. They no longer light all segments.
- Leading-zero suppression:
  - When lz_blank = 1, digit k is blank (out_seg all ones, dp still honoured) if hold_val nibbles DIGITS-1..k are all zero and k != 0.
  - Digit 0 is never blanked.
  - Dash codes count as non-zero.
- Decimal point: dp = ~hold_dp[idx].
- Simultaneous events:
  - load and tick on the same edge: both take effect, and the new digit shows the new value.
  - reset overrides load and tick.
  - Reset mid-slot restarts scanning at digit 0 with a full slot.
- DIGITS = 1: idx is constant 0, and the anti-ghost cycle still occurs once per SCAN_DIV.

Optional Feature:
- Macro SEVEN_SEG_BLINK_EN.
- Defined:
  - Adds input blink (DIGITS bits) and parameter BLINK_FRAMES (default 64).
  - A frame counter increments once per full scan (idx wrap) and a phase bit toggles every BLINK_FRAMES frames. Both reset to 0.
  - While phase = 1, digits with blink[k] = 1 are blanked, segments and dp.
  - blink is sampled directly, not through load. This is used for the "parking full" flash.
- Undefined: no blink port, no frame counter, behaviour exactly as above.

Decomposition:
- Package seg7_pkg holds:
  - Glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (7-bit, active-low).
  - Localparam AN_OFF helper.
  - Function width rule for idx, $clog2(DIGITS) with minimum 1.
- Sub-module seven_seg_decode: purely combinational 4-bit to 7-bit glyph lookup using the package constants. Instantiated once on the selected nibble. seven_segment_scan owns all sequential logic.

Test Plan (DIGITS = 4, SCAN_DIV = 4 unless noted):
- Reset held 3 cycles then released -> an = 1111, out_seg = 1111111, dp = 1 during reset; first active slot an = 1110 showing 0000001.
- load value = 16'h1234, lz_blank = 0 -> slots cycle an 1110/1101/1011/0111 with out_seg 1001100/0000110/0010010/1001111. Each slot is 4 cycles: 1 blank plus 3 driven.
- load value = 16'h0050, lz_blank = 1 -> digit 3 and digit 2 blank (1111111), digit 1 = 0100100, digit 0 = 0000001. Load 16'h0000 -> only digit 0 lit.
- load value = 16'hA00F, dp_in = 4'b0100 -> digits 3 and 0 show 1111110; dp = 0 only while an = 1011.
- load asserted on the same edge as tick -> the next digit shows the new nibble; reset asserted mid-slot -> all off next cycle, scan restarts at digit 0.
- With SEVEN_SEG_BLINK_EN, BLINK_FRAMES = 2, blink = 4'b0001 -> digit 0 blank for 2 frames, lit for 2 frames, repeating; other digits unaffected.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Glyphs are active-low {a,b,c,d,e,f,g} with a in bit 6.
// No ports; imported by seven_seg_decode and seven_segment_scan.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Widest supported anode bus, all digits disabled; slice to DIGITS bits.
  localparam logic [7:0] AN_OFF = 8'hFF;

  // Counter width able to index `count` entries, never narrower than 1 bit.
  function automatic int idx_width(input int count);
    if (count > 1) return $clog2(count);
    else           return 1;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD-to-glyph lookup.
// Ports:
//   code : 4-bit digit code; 0..9 map to numerals, 10..15 show a dash
//   seg  : 7-bit active-low segment pattern {a,b,c,d,e,f,g}
module seven_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed driver for DIGITS common-anode seven-segment digits.
// Optional feature macro: SEVEN_SEG_BLINK_EN (adds blink input and
// BLINK_FRAMES parameter for whole-digit flashing).
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   value    : BCD nibbles, nibble 0 = rightmost digit
//   load     : captures value / dp_in into the holding registers
//   lz_blank : enables leading-zero suppression
//   dp_in    : per-digit decimal point request, 1 = lit
//   blink    : (SEVEN_SEG_BLINK_EN only) per-digit flash enable
//   out_seg  : segments {a..g}, active-low, registered
//   dp       : decimal point, active-low, registered
//   an       : digit enables, active-low, at most one low, registered
//
// Scan states (idx, one slot each):
//   state             | meaning
//   idx = k, cnt = 0  | anti-ghost cycle, everything dark
//   idx = k, cnt > 0  | digit k driven from holding registers
module seven_segment_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
`ifdef SEVEN_SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     dp_in,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink,
`endif
  output logic [6:0]            out_seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int                IDX_W      = idx_width(DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [DIGITS-1:0] AN_ALL_OFF = AN_OFF[DIGITS-1:0];

  logic [4*DIGITS-1:0] hold_val;
  logic [DIGITS-1:0]   hold_dp;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  logic                tick;
  logic                slot_start;
  logic [3:0]          nibble;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic                lz_off;
  logic                blink_off;

  assign tick       = (cnt == CNT_LAST);
  // idx changed on the previous edge exactly when cnt is back at zero.
  assign slot_start = (cnt == '0);
  assign nibble     = hold_val[{idx, 2'b00} +: 4];

  seven_seg_decode u_decode (
    .code (nibble),
    .seg  (glyph)
  );

  // Digit k is a leading zero when it and every digit above it hold 0.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (hold_val[4*k +: 4] == 4'd0);
      if (k != 0) lz_mask[k] = zero_run;
    end
  end

  assign lz_off = lz_blank & lz_mask[idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_val <= '0;
      hold_dp  <= '0;
    end else if (load) begin
      hold_val <= value;
      hold_dp  <= dp_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int               FR_W    = idx_width(BLINK_FRAMES);
  localparam logic [FR_W-1:0]  FR_LAST = FR_W'(BLINK_FRAMES - 1);

  logic [FR_W-1:0] frame_cnt;
  logic            phase;

  // One frame = one full pass over all digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (tick && (idx == IDX_LAST)) begin
      if (frame_cnt == FR_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_off = phase & blink[idx];
`else
  assign blink_off = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || slot_start) begin
      out_seg <= SEG_OFF;
      dp      <= 1'b1;
      an      <= AN_ALL_OFF;
    end else begin
      an      <= ~(DIGITS'(1) << idx);
      out_seg <= (lz_off | blink_off) ? SEG_OFF : glyph;
      dp      <= ~hold_dp[idx] | blink_off;
    end
  end

endmodule
